cl_pcim_wr_master: RTL and testbench
====================================

Name: cl_pcim_wr_master

Overview:
AXI4 write initiator on the PCIM interface, the host-bound counterpart of the DMA PCIS write responder.
- Drains a 512-bit valid/ready stream, typically the output data FIFO after the CNN pipeline.
- Writes the stream into host memory as incrementing AW/W bursts starting at a programmed base address.
- Tracks B responses and reports completion and errors to a control block.

Parameters:
DATA_W, 512, data/stream width in bits (64-byte beats)
ADDR_W, 64, AXI address width
ID_W, 16, AXI ID width
AXI_ID, 0, constant value driven on awid
MAX_BURST, 16, maximum beats per burst (awlen = MAX_BURST-1 max)
MAX_OUTST, 4, maximum AW bursts awaiting B response

Ports:
clk  in  1  clock (clk_main_a0 domain)
srst  in  1  synchronous active-high reset
cfg_start  in  1  one-cycle pulse: latch cfg_base_addr/cfg_num_beats and begin
cfg_base_addr  in  ADDR_W  host byte address; bits [5:0] ignored (forced 0)
cfg_num_beats  in  32  total 64-byte beats to write
busy  out  1  transfer in progress
done  out  1  one-cycle pulse: all beats written and all B received
err  out  1  sticky: any bresp != OKAY since last cfg_start
s_tdata / s_tvalid / s_tready  in/in/out  DATA_W/1/1  input stream
awid / awaddr / awlen / awsize  out  ID_W/ADDR_W/8/3  AW payload; awsize fixed 3'b110
awvalid / awready  out/in  1/1  AW handshake
wdata / wstrb / wlast  out  DATA_W/DATA_W/8/1  W payload; wstrb all ones
wvalid / wready  out/in  1/1  W handshake
bid / bresp  in  ID_W/2  B payload; bid ignored
bvalid / bready  in/out  1/1  B handshake

Behaviour:
- Reset values: awvalid=0, wvalid=0, wlast=0, s_tready=0, bready=0, busy=0, done=0, err=0, outstanding=0, state=IDLE.
- FSM states: IDLE, ADDR, DATA, DRAIN.
- IDLE:
  - cfg_start with num_beats=0: done=1 next cycle, no AXI traffic.
  - cfg_start with num_beats>0: latch addr (low 6 bits zeroed) and remaining=num_beats, clear err, busy=1, go to ADDR.
  - cfg_start in any other state is ignored.
- ADDR:
  - Burst length = min(remaining, MAX_BURST, beats left to the next 4 KB boundary).
  - awvalid asserts only when outstanding < MAX_OUTST.
  - AW payload is held stable until awready.
  - On handshake: addr += len*64, remaining -= len, go to DATA.
- DATA:
  - wvalid = s_tvalid; s_tready = wready; wdata = s_tdata (combinational pass-through, zero latency).
  - wlast=1 on beat index = len-1.
  - On wlast handshake: go to ADDR if remaining>0, else DRAIN.
  - No W beat is issued before its own AW handshake.
- Outstanding counter: +1 on AW handshake, -1 on B handshake, unchanged when both occur in the same cycle. It never exceeds MAX_OUTST.
- B channel: bready=1 whenever busy. Any bresp != 2'b00 sets err, which stays set until the next accepted cfg_start.
- DRAIN: when outstanding=0, assert done for 1 cycle, busy=0, go to IDLE. done and busy=0 occur in the same cycle.
- 4 KB rule: no burst crosses a 4096-byte address boundary. A split burst continues at the boundary.
- Backpressure:
  - awready low holds state ADDR indefinitely.
  - wready or s_tvalid low stalls DATA with no beat lost or duplicated.
- srst mid-transfer takes effect next edge:
  - all valids drop, FSM returns to IDLE, counters clear.
  - in-flight B responses arriving after reset are not counted.
  - no done pulse is generated.

Decomposition:
- Package cl_pcim_pkg holds:
  - state enum: IDLE/ADDR/DATA/DRAIN.
  - constants: AXI_SIZE_64B=3'b110, RESP_OKAY=2'b00, BOUNDARY_4K=4096, BEAT_BYTES=64.
- One natural sub-module: cl_pcim_burst_calc. It is combinational/registered and computes burst length from addr, remaining and MAX_BURST, including the 4 KB clip.

Test Plan:
- num_beats=32, base=0x1000, awready/wready always 1 -> two AW bursts at 0x1000 and 0x1400, awlen=15 each; wlast on beats 16 and 32; done 1 cycle after 2nd B; err=0.
- num_beats=5, base=0x0FC0 -> first burst awaddr=0x0FC0 awlen=0 (1 beat to 4K), second awaddr=0x1000 awlen=3; done after 2 B.
- 80 beats, bvalid withheld -> exactly 4 AW handshakes then awvalid stays 0; releasing one B lets the 5th AW issue; done after 5 B.
- Random wready/s_tvalid gaps, 48 beats of incrementing pattern -> host model receives beats 0..47 in order, none duplicated.
- 2nd B returns bresp=2'b10 -> err=1 at done and stays 1; next cfg_start clears err.
- srst asserted during beat 7 of 16 -> next cycle awvalid=wvalid=busy=0; fresh cfg_start then completes normally. cfg_start with num_beats=0 -> done pulse, no AW.

Source files
------------

// File: rtl/cl_pcim_pkg.sv
// Shared constants, state encodings and helpers for the PCIM AXI4 write initiator.
package cl_pcim_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t ADDR  = 2'd1;
  localparam state_t DATA  = 2'd2;
  localparam state_t DRAIN = 2'd3;

  localparam logic [2:0] AXI_SIZE_64B = 3'b110;
  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam int         BOUNDARY_4K  = 4096;
  localparam int         BEAT_BYTES   = 64;

  // Whole 64-byte beats left before the next 4 KB page starts (1..64).
  function automatic logic [6:0] beats_to_4k(input logic [11:0] pageOffs);
    return 7'((BOUNDARY_4K - int'(pageOffs)) / BEAT_BYTES);
  endfunction

endpackage

// File: rtl/cl_pcim_burst_calc.sv
// Burst length for the next AW: min of remaining beats, MAX_BURST and the room left in the 4 KB page.
module cl_pcim_burst_calc
  import cl_pcim_pkg::*;
#(
  parameter int MAX_BURST = 16
) (
  input  logic [11:0] pageOffs_i,
  input  logic [31:0] remaining_i,
  output logic [8:0]  len_o
);

  logic [31:0] toBoundary;
  logic [31:0] lim;

  always_comb begin
    toBoundary = {25'd0, beats_to_4k(pageOffs_i)};
    lim        = 32'(MAX_BURST);
    if (toBoundary < lim) lim = toBoundary;
    if (remaining_i < lim) lim = remaining_i;
    len_o = 9'(lim);
  end

endmodule

// File: rtl/cl_pcim_wr_master.sv
// AXI4 write initiator: drains a 512-bit stream into host memory as 4 KB-safe incrementing bursts
// and reports completion / sticky error once every B response has come back.
module cl_pcim_wr_master
  import cl_pcim_pkg::*;
#(
  parameter int DATA_W    = 512,
  parameter int ADDR_W    = 64,
  parameter int ID_W      = 16,
  parameter int AXI_ID    = 0,
  parameter int MAX_BURST = 16,
  parameter int MAX_OUTST = 4
) (
  input  logic                clk,
  input  logic                srst,
  input  logic                cfg_start,
  input  logic [ADDR_W-1:0]   cfg_base_addr,
  input  logic [31:0]         cfg_num_beats,
  output logic                busy,
  output logic                done,
  output logic                err,
  input  logic [DATA_W-1:0]   s_tdata,
  input  logic                s_tvalid,
  output logic                s_tready,
  output logic [ID_W-1:0]     awid,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [ID_W-1:0]     bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  localparam int OUT_W = $clog2(MAX_OUTST + 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       remaining_q, remaining_d;
  logic [8:0]        len_q, len_d;
  logic [8:0]        beatCnt_q, beatCnt_d;
  logic [OUT_W-1:0]  outst_q, outst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [8:0] burstLen;
  logic       awHs, wHs, bHs;
  logic       unused_ok;

  assign unused_ok = ^{bid, cfg_base_addr[5:0]};

  cl_pcim_burst_calc #(
    .MAX_BURST(MAX_BURST)
  ) u_burst_calc (
    .pageOffs_i (addr_q[11:0]),
    .remaining_i(remaining_q),
    .len_o      (burstLen)
  );

  assign awid    = ID_W'(AXI_ID);
  assign awaddr  = addr_q;
  assign awlen   = 8'(burstLen - 9'd1);
  assign awsize  = AXI_SIZE_64B;
  assign awvalid = (state_q == ADDR) && (outst_q < OUT_W'(MAX_OUTST));

  // W is a zero-latency pass-through of the stream while a burst is open.
  assign wdata    = s_tdata;
  assign wstrb    = '1;
  assign wvalid   = (state_q == DATA) && s_tvalid;
  assign s_tready = (state_q == DATA) && wready;
  assign wlast    = (state_q == DATA) && (beatCnt_q == len_q - 9'd1);

  assign bready = busy_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;

  assign awHs = awvalid && awready;
  assign wHs  = wvalid && wready;
  assign bHs  = bvalid && bready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    len_d       = len_q;
    beatCnt_d   = beatCnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    outst_d     = outst_q;

    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          err_d = 1'b0;
          if (cfg_num_beats == 32'd0) begin
            done_d = 1'b1;
          end else begin
            addr_d      = {cfg_base_addr[ADDR_W-1:6], 6'b0};
            remaining_d = cfg_num_beats;
            busy_d      = 1'b1;
            state_d     = ADDR;
          end
        end
      end
      ADDR: begin
        if (awHs) begin
          addr_d      = addr_q + ADDR_W'({burstLen, 6'b0});
          remaining_d = remaining_q - 32'(burstLen);
          len_d       = burstLen;
          beatCnt_d   = 9'd0;
          state_d     = DATA;
        end
      end
      DATA: begin
        if (wHs) begin
          beatCnt_d = beatCnt_q + 9'd1;
          if (wlast) state_d = (remaining_q != 32'd0) ? ADDR : DRAIN;
        end
      end
      default: begin
        if (outst_q == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
    endcase

    if (awHs && !bHs) begin
      outst_d = outst_q + OUT_W'(1);
    end else if (bHs && !awHs && outst_q != '0) begin
      outst_d = outst_q - OUT_W'(1);
    end

    if (bHs && bresp != RESP_OKAY) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      len_q       <= '0;
      beatCnt_q   <= '0;
      outst_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      len_q       <= len_d;
      beatCnt_q   <= beatCnt_d;
      outst_q     <= outst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_cl_pcim_wr_master.sv
// Self-checking bench: randomized AXI/stream handshakes against a host-side model of the
// expected burst plan, beat order, B accounting and completion/error reporting.
module tb_cl_pcim_wr_master;

  localparam int DATA_W    = 512;
  localparam int ADDR_W    = 64;
  localparam int ID_W      = 16;
  localparam int MAX_BURST = 16;
  localparam int MAX_OUTST = 4;

  typedef struct {
    logic [63:0] addr;
    int          len;
  } burst_t;

  logic                clk = 1'b0;
  logic                srst = 1'b1;
  logic                cfg_start = 1'b0;
  logic [ADDR_W-1:0]   cfg_base_addr = '0;
  logic [31:0]         cfg_num_beats = '0;
  logic                busy, done, err;
  logic [DATA_W-1:0]   s_tdata;
  logic                s_tvalid;
  logic                s_tready;
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic                awvalid;
  logic                awready = 1'b1;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast, wvalid;
  logic                wready = 1'b1;
  logic [ID_W-1:0]     bid = '0;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  int checks = 0;
  int errors = 0;

  burst_t            expBursts[$];
  burst_t            obsAw[$];
  int                openLens[$];
  int                obsLast[$];
  logic [DATA_W-1:0] srcQ[$];
  logic [DATA_W-1:0] expData[$];
  int  beatInBurst = 0, xferBeat = 0, outM = 0;
  int  awCount = 0, wCount = 0, bCount = 0, doneCount = 0;
  int  bPending = 0, bAllow = -1, bIdx = 0, errIdx = 0;
  bit  errM = 1'b0, gaps = 1'b0;

  cl_pcim_wr_master #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .AXI_ID(0),
    .MAX_BURST(MAX_BURST), .MAX_OUTST(MAX_OUTST)
  ) dut (
    .clk(clk), .srst(srst), .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr),
    .cfg_num_beats(cfg_num_beats), .busy(busy), .done(done), .err(err),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic checkData(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual[63:0]=0x%0h expected[63:0]=0x%0h", name, act[63:0], exp[63:0]);
    end
  endtask

  // Host-side burst plan: greedy split by max burst and 4 KB pages.
  function automatic void planBursts(input logic [63:0] base, input int n);
    logic [63:0] a;
    int rem, toB, l;
    a   = base & ~64'h3F;
    rem = n;
    while (rem > 0) begin
      toB = (4096 - int'(a % 64'd4096)) / 64;
      l = rem;
      if (l > MAX_BURST) l = MAX_BURST;
      if (l > toB) l = toB;
      expBursts.push_back('{a, l});
      a   = a + 64'(l * 64);
      rem = rem - l;
    end
  endfunction

  task automatic applyStimulus(input logic [63:0] base, input int n, input bit incr);
    logic [DATA_W-1:0] beat;
    @(posedge clk); #1;
    planBursts(base, n);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < DATA_W / 32; k++)
        beat[k*32 +: 32] = incr ? ((32'(i) << 8) | 32'(k)) : $urandom();
      srcQ.push_back(beat);
      expData.push_back(beat);
    end
    obsAw.delete();
    obsLast.delete();
    xferBeat = 0;
    bIdx = 0;
    errM = 1'b0;
    cfg_start = 1'b1;
    cfg_base_addr = base;
    cfg_num_beats = 32'(n);
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int d0;
    bit ok;
    d0 = doneCount;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (doneCount != d0) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("done_seen", ok, 1);
  endtask

  task automatic flushModel();
    srcQ.delete(); expData.delete(); expBursts.delete(); openLens.delete();
    beatInBurst = 0; outM = 0; bPending = 0; bAllow = -1;
    s_tvalid = 1'b0; bvalid = 1'b0;
  endtask

  task automatic resetDut();
    srst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    flushModel();
    @(posedge clk); #1;
    srst = 1'b0;
  endtask

  // Stream source: holds a beat until accepted, optional random bubbles.
  initial begin
    bit sh;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    forever begin
      @(negedge clk);
      sh = s_tvalid && s_tready && !srst;
      @(posedge clk); #1;
      if (sh) begin
        if (srcQ.size() > 0) void'(srcQ.pop_front());
        s_tvalid = 1'b0;
      end
      if (!s_tvalid && srcQ.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) s_tvalid = 1'b1;
      if (srcQ.size() > 0) s_tdata = srcQ[0];
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      awready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      wready  = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // B responder: one response per completed burst, gated by bAllow (-1 = unlimited).
  initial begin
    bit bh;
    bvalid = 1'b0;
    bresp  = 2'b00;
    forever begin
      @(negedge clk);
      bh = bvalid && bready && !srst;
      @(posedge clk); #1;
      if (bh) begin
        bvalid = 1'b0;
        bPending--;
        bIdx++;
        if (bAllow > 0) bAllow--;
      end
      if (!bvalid && bPending > 0 && bAllow != 0 && (!gaps || $urandom_range(0, 2) == 0)) begin
        bvalid = 1'b1;
        bresp  = (bIdx + 1 == errIdx) ? 2'b10 : 2'b00;
      end
    end
  end

  // Compare process: every cycle the DUT is out of reset.
  initial begin
    bit awHs, wHs, bHs;
    burst_t b;
    logic [DATA_W-1:0] e;
    forever begin
      @(negedge clk);
      if (!srst) begin
        awHs = awvalid && awready;
        wHs  = wvalid && wready;
        bHs  = bvalid && bready;
        checkOutput("bready_eq_busy", bready, busy);
        if (awvalid) checkOutput("aw_outst_limit", outM < MAX_OUTST, 1);
        if (awHs) begin
          obsAw.push_back('{awaddr, int'(awlen) + 1});
          if (expBursts.size() == 0) begin
            checkOutput("aw_unexpected", 1, 0);
          end else begin
            b = expBursts.pop_front();
            checkOutput("awaddr", awaddr, b.addr);
            checkOutput("awlen", awlen, 64'(b.len - 1));
            checkOutput("awsize", awsize, 3'b110);
            checkOutput("awid", awid, 0);
            openLens.push_back(b.len);
          end
          awCount++;
        end
        if (wvalid) begin
          checkOutput("w_after_aw", openLens.size() > 0, 1);
          checkData("wdata_passthru", wdata, s_tdata);
          checkOutput("tready_eq_wready", s_tready, wready);
        end
        if (s_tvalid && s_tready) checkOutput("stream_beat_to_w", wvalid, 1);
        if (wHs && openLens.size() > 0) begin
          if (expData.size() == 0) begin
            checkOutput("w_extra_beat", 1, 0);
          end else begin
            e = expData.pop_front();
            checkData("wdata_order", wdata, e);
          end
          checkOutput("wstrb_ones", &wstrb, 1);
          checkOutput("wlast", wlast, beatInBurst == openLens[0] - 1);
          beatInBurst++;
          xferBeat++;
          wCount++;
          if (wlast) obsLast.push_back(xferBeat);
          if (beatInBurst == openLens[0]) begin
            void'(openLens.pop_front());
            beatInBurst = 0;
            bPending++;
          end
        end
        if (bHs) begin
          bCount++;
          outM--;
          if (bresp != 2'b00) errM = 1'b1;
        end
        if (awHs) outM++;
        if (done) begin
          doneCount++;
          checkOutput("done_busy_low", busy, 0);
          checkOutput("done_all_aw", expBursts.size(), 0);
          checkOutput("done_all_w", expData.size(), 0);
          checkOutput("done_all_b", outM, 0);
          checkOutput("done_err", err, errM);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int aw0, b0, w0, d0;
    bit ok;

    // Pin the burst planner against hand-worked cases.
    planBursts(64'h0FC0, 5);
    checkOutput("plan_a_n", expBursts.size(), 2);
    checkOutput("plan_a0_addr", expBursts[0].addr, 64'h0FC0);
    checkOutput("plan_a0_len", expBursts[0].len, 1);
    checkOutput("plan_a1_addr", expBursts[1].addr, 64'h1000);
    checkOutput("plan_a1_len", expBursts[1].len, 4);
    expBursts.delete();
    planBursts(64'h0F00, 40);
    checkOutput("plan_b_n", expBursts.size(), 4);
    checkOutput("plan_b0_len", expBursts[0].len, 4);
    checkOutput("plan_b3_addr", expBursts[3].addr, 64'h1800);
    checkOutput("plan_b3_len", expBursts[3].len, 4);
    expBursts.delete();

    resetDut();
    @(negedge clk);
    checkOutput("rst_awvalid", awvalid, 0);
    checkOutput("rst_wvalid", wvalid, 0);
    checkOutput("rst_wlast", wlast, 0);
    checkOutput("rst_tready", s_tready, 0);
    checkOutput("rst_bready", bready, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);

    $display("[TB] 32 beats at 0x1000");
    gaps = 0;
    applyStimulus(64'h1000, 32, 1'b1);
    @(negedge clk);
    checkOutput("t1_busy", busy, 1);
    waitDone(1000);
    checkOutput("t1_naw", obsAw.size(), 2);
    checkOutput("t1_aw0_addr", obsAw[0].addr, 64'h1000);
    checkOutput("t1_aw0_len", obsAw[0].len, 16);
    checkOutput("t1_aw1_addr", obsAw[1].addr, 64'h1400);
    checkOutput("t1_aw1_len", obsAw[1].len, 16);
    checkOutput("t1_last0", obsLast[0], 16);
    checkOutput("t1_last1", obsLast[1], 32);
    checkOutput("t1_err", err, 0);

    $display("[TB] 5 beats at 0x0FC0");
    b0 = bCount;
    applyStimulus(64'h0FC0, 5, 1'b1);
    waitDone(1000);
    checkOutput("t2_naw", obsAw.size(), 2);
    checkOutput("t2_aw0_addr", obsAw[0].addr, 64'h0FC0);
    checkOutput("t2_aw0_len", obsAw[0].len, 1);
    checkOutput("t2_aw1_addr", obsAw[1].addr, 64'h1000);
    checkOutput("t2_aw1_len", obsAw[1].len, 4);
    checkOutput("t2_nb", bCount - b0, 2);

    $display("[TB] 80 beats with B withheld");
    aw0 = awCount;
    b0 = bCount;
    bAllow = 0;
    applyStimulus(64'h0, 80, 1'b1);
    repeat (300) @(negedge clk);
    checkOutput("t3_aw_stalled", awCount - aw0, 4);
    checkOutput("t3_awvalid_low", awvalid, 0);
    checkOutput("t3_busy", busy, 1);
    bAllow = 1;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (awCount - aw0 == 5) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("t3_fifth_aw", ok, 1);
    bAllow = -1;
    waitDone(1000);
    checkOutput("t3_nb", bCount - b0, 5);

    $display("[TB] 48 beats with random gaps");
    gaps = 1;
    w0 = wCount;
    applyStimulus(64'h0000_0002_0000_0E40, 48, 1'b1);
    waitDone(3000);
    checkOutput("t4_beats", wCount - w0, 48);

    for (int t = 0; t < 4; t++) begin
      errIdx = $urandom_range(0, 3);
      applyStimulus({$urandom(), $urandom()}, $urandom_range(1, 70), 1'b0);
      waitDone(5000);
    end

    $display("[TB] error on second B");
    gaps = 0;
    errIdx = 2;
    applyStimulus(64'h8000, 32, 1'b1);
    waitDone(1000);
    checkOutput("t5_err_at_done", err, 1);
    repeat (5) @(negedge clk);
    checkOutput("t5_err_sticky", err, 1);
    errIdx = 0;
    applyStimulus(64'h9000, 16, 1'b1);
    @(negedge clk);
    checkOutput("t5_err_cleared", err, 0);
    waitDone(1000);

    $display("[TB] reset mid-burst");
    w0 = wCount;
    applyStimulus(64'h0, 16, 1'b1);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (wCount - w0 >= 7) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("t6_reach_beat7", ok, 1);
    @(posedge clk); #1;
    srst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("t6_awvalid", awvalid, 0);
    checkOutput("t6_wvalid", wvalid, 0);
    checkOutput("t6_busy", busy, 0);
    d0 = doneCount;
    resetDut();
    repeat (5) @(negedge clk);
    checkOutput("t6_no_done", doneCount - d0, 0);
    applyStimulus(64'h3000, 16, 1'b1);
    waitDone(1000);

    $display("[TB] zero-beat start");
    aw0 = awCount;
    d0 = doneCount;
    applyStimulus(64'h5000, 0, 1'b1);
    @(negedge clk);
    checkOutput("t7_done", done, 1);
    checkOutput("t7_busy", busy, 0);
    repeat (4) @(negedge clk);
    checkOutput("t7_no_aw", awCount - aw0, 0);
    checkOutput("t7_one_done", doneCount - d0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
